// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory controller: FSM states and access size codes.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } state_t;

  localparam logic [2:0] SIZE_BYTE = 3'd1;
  localparam logic [2:0] SIZE_HALF = 3'd2;
  localparam logic [2:0] SIZE_WORD = 3'd4;

  // Anything that is not a byte or halfword access moves a full word.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      SIZE_BYTE: return SIZE_BYTE;
      SIZE_HALF: return SIZE_HALF;
      default:   return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and load/store masters onto a byte-wide RAM port, serialising
// little-endian multi-byte accesses and honouring misbranch rollback.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_rollback,
  input  logic              in_if_ena,
  input  logic [ADDR_W-1:0] in_if_addr,
  output logic              out_if_ready,
  output logic [DATA_W-1:0] out_if_data,
  input  logic              in_ls_ena,
  input  logic              in_ls_iswrite,
  input  logic [ADDR_W-1:0] in_ls_addr,
  input  logic [2:0]        in_ls_size,
  input  logic [DATA_W-1:0] in_ls_write_data,
  output logic              out_ls_ready,
  output logic [DATA_W-1:0] out_ls_read_data,
  input  logic [7:0]        in_ram_din,
  output logic [7:0]        out_ram_dout,
  output logic [ADDR_W-1:0] out_ram_a,
  output logic              out_ram_wr
);
  import mem_ctrl_pkg::*;

  state_t            state;
  logic [2:0]        step;
  logic [2:0]        cur_n;
  logic              cur_ls;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [DATA_W-1:0] asm_data;

  logic              if_pend;
  logic [ADDR_W-1:0] if_addr;
  logic              ls_pend;
  logic              ls_write;
  logic [ADDR_W-1:0] ls_addr;
  logic [2:0]        ls_n;
  logic [DATA_W-1:0] ls_wdata;

  logic              ls_cand, ls_c_write;
  logic [ADDR_W-1:0] ls_c_addr;
  logic [2:0]        ls_c_n;
  logic [DATA_W-1:0] ls_c_wdata;
  logic              if_cand;
  logic [ADDR_W-1:0] if_c_addr;
  logic              take_ls, take_if;
  logic [ADDR_W-1:0] step_addr;
  logic [2:0]        rd_idx;

  // Candidates merge the latch with a same-edge pulse; rollback filters reads out.
  always_comb begin
    ls_cand    = '0;
    ls_c_write = '0;
    ls_c_addr  = '0;
    ls_c_n     = SIZE_WORD;
    ls_c_wdata = '0;
    if (ls_pend && !(in_rollback && !ls_write)) begin
      ls_cand    = '1;
      ls_c_write = ls_write;
      ls_c_addr  = ls_addr;
      ls_c_n     = ls_n;
      ls_c_wdata = ls_wdata;
    end else if (in_ls_ena && !(in_rollback && !in_ls_iswrite)) begin
      ls_cand    = '1;
      ls_c_write = in_ls_iswrite;
      ls_c_addr  = in_ls_addr;
      ls_c_n     = size_bytes(in_ls_size);
      ls_c_wdata = in_ls_write_data;
    end
    if_cand   = (if_pend || in_if_ena) && !in_rollback;
    if_c_addr = if_pend ? if_addr : in_if_addr;
    take_ls   = (state == MEM_IDLE) && ls_cand;
    take_if   = (state == MEM_IDLE) && if_cand && !ls_cand;
    step_addr = cur_addr + ADDR_W'(step);
    rd_idx    = step - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= MEM_IDLE;
      step             <= '0;
      cur_n            <= '0;
      cur_ls           <= '0;
      cur_addr         <= '0;
      cur_wdata        <= '0;
      asm_data         <= '0;
      if_pend          <= '0;
      if_addr          <= '0;
      ls_pend          <= '0;
      ls_write         <= '0;
      ls_addr          <= '0;
      ls_n             <= '0;
      ls_wdata         <= '0;
      out_if_ready     <= '0;
      out_if_data      <= '0;
      out_ls_ready     <= '0;
      out_ls_read_data <= '0;
      out_ram_dout     <= '0;
      out_ram_a        <= '0;
      out_ram_wr       <= '0;
    end else begin
      out_if_ready <= '0;
      out_ls_ready <= '0;
      out_ram_wr   <= '0;
      if (ena) begin
        ls_pend <= ls_cand && !take_ls;
        if (ls_cand) begin
          ls_write <= ls_c_write;
          ls_addr  <= ls_c_addr;
          ls_n     <= ls_c_n;
          ls_wdata <= ls_c_wdata;
        end
        if_pend <= if_cand && !take_if;
        if (if_cand) if_addr <= if_c_addr;

        case (state)
          MEM_IDLE: begin
            step     <= '0;
            asm_data <= '0;
            if (take_ls) begin
              cur_ls    <= '1;
              cur_addr  <= ls_c_addr;
              cur_n     <= ls_c_n;
              cur_wdata <= ls_c_wdata;
              state     <= ls_c_write ? MEM_WRITE : MEM_READ;
            end else if (take_if) begin
              cur_ls   <= '0;
              cur_addr <= if_c_addr;
              cur_n    <= SIZE_WORD;
              state    <= MEM_READ;
            end
          end
          // step k drives address k, captures the byte addressed at step k-1,
          // and step n+1 hands the assembled word to the owning master.
          MEM_READ: begin
            if (in_rollback) begin
              state <= MEM_IDLE;
              step  <= '0;
            end else begin
              if (step < cur_n) out_ram_a <= step_addr;
              if (step != 3'd0 && step <= cur_n)
                asm_data[int'(rd_idx)*8 +: 8] <= in_ram_din;
              if (step == cur_n + 3'd1) begin
                if (cur_ls) begin
                  out_ls_ready     <= '1;
                  out_ls_read_data <= asm_data;
                end else begin
                  out_if_ready <= '1;
                  out_if_data  <= asm_data;
                end
                state <= MEM_IDLE;
                step  <= '0;
              end else begin
                step <= step + 3'd1;
              end
            end
          end
          MEM_WRITE: begin
            if (step < cur_n) begin
              out_ram_wr   <= '1;
              out_ram_a    <= step_addr;
              out_ram_dout <= cur_wdata[int'(step)*8 +: 8];
              step         <= step + 3'd1;
            end else begin
              out_ls_ready <= '1;
              state        <= MEM_IDLE;
              step         <= '0;
            end
          end
          default: state <= MEM_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with an asynchronous-read byte RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, ena, in_rollback;
  logic        in_if_ena;
  logic [31:0] in_if_addr;
  logic        out_if_ready;
  logic [31:0] out_if_data;
  logic        in_ls_ena, in_ls_iswrite;
  logic [31:0] in_ls_addr;
  logic [2:0]  in_ls_size;
  logic [31:0] in_ls_write_data;
  logic        out_ls_ready;
  logic [31:0] out_ls_read_data;
  logic [7:0]  in_ram_din, out_ram_dout;
  logic [31:0] out_ram_a;
  logic        out_ram_wr;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_a;
  logic [7:0]  pl_d;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_rollback(in_rollback),
    .in_if_ena(in_if_ena), .in_if_addr(in_if_addr),
    .out_if_ready(out_if_ready), .out_if_data(out_if_data),
    .in_ls_ena(in_ls_ena), .in_ls_iswrite(in_ls_iswrite), .in_ls_addr(in_ls_addr),
    .in_ls_size(in_ls_size), .in_ls_write_data(in_ls_write_data),
    .out_ls_ready(out_ls_ready), .out_ls_read_data(out_ls_read_data),
    .in_ram_din(in_ram_din), .out_ram_dout(out_ram_dout),
    .out_ram_a(out_ram_a), .out_ram_wr(out_ram_wr)
  );

  assign in_ram_din = mem[out_ram_a[11:0]];

  always @(posedge clk) begin
    if (out_ram_wr) mem[out_ram_a[11:0]] <= out_ram_dout;
    else if (pl_en) mem[pl_a] <= pl_d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ls(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] d);
    in_ls_ena = 1'b1; in_ls_iswrite = wr; in_ls_addr = a; in_ls_size = sz;
    in_ls_write_data = d;
    tick();
    in_ls_ena = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] pa [14] = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h000, 12'h001, 12'h002,
                             12'h003, 12'h040, 12'h041, 12'h042, 12'h043, 12'hFFE, 12'hFFF};
    logic [7:0]  pd [14] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h01, 8'h02, 8'h03,
                             8'h04, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h77, 8'h66};
    rst = 1'b1; ena = 1'b1; in_rollback = 1'b0; in_if_ena = 1'b0; in_if_addr = '0;
    in_ls_ena = 1'b0; in_ls_iswrite = 1'b0; in_ls_addr = '0; in_ls_size = 3'd4;
    in_ls_write_data = '0; pl_en = 1'b0; pl_a = '0; pl_d = '0;
    tick();
    for (int i = 0; i < 14; i++) begin
      pl_en = 1'b1; pl_a = pa[i]; pl_d = pd[i];
      tick();
    end
    pl_en = 1'b0;
    tick();
    vectors++;
    if ({out_if_ready, out_ls_ready, out_ram_wr} !== 3'b000) begin
      miscompares++; $display("FAIL reset_strobes: got %b want 000", {out_if_ready, out_ls_ready, out_ram_wr});
    end
    vectors++;
    if ({out_if_data, out_ls_read_data, out_ram_a, out_ram_dout} !== 104'd0) begin
      miscompares++; $display("FAIL reset_buses: if_data %h ls_data %h a %h dout %h want 0",
                              out_if_data, out_ls_read_data, out_ram_a, out_ram_dout);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_word();
    pulse_ls(1'b0, 32'h100, 3'd4, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (out_ram_a !== 32'h100 + 32'(k) || out_ls_ready !== 1'b0) begin
        miscompares++; $display("FAIL load4_addr edge%0d: a %h rdy %b want %h rdy 0",
                                k + 1, out_ram_a, out_ls_ready, 32'h100 + 32'(k));
      end
    end
    tick();
    vectors++;
    if (out_ls_ready !== 1'b0) begin
      miscompares++; $display("FAIL load4_early: ready %b at edge 5 want 0", out_ls_ready);
    end
    tick();
    vectors++;
    if (out_ls_ready !== 1'b1 || out_ls_read_data !== 32'h44332211) begin
      miscompares++; $display("FAIL load4_data: ready %b data %h want 1 44332211",
                              out_ls_ready, out_ls_read_data);
    end
    tick();
    vectors++;
    if (out_ls_ready !== 1'b0) begin
      miscompares++; $display("FAIL load4_pulse: ready %b after one cycle want 0", out_ls_ready);
    end
  endtask

  task automatic test_store_byte();
    pulse_ls(1'b1, 32'h204, 3'd1, 32'h123456AB);
    tick();
    vectors++;
    if (out_ram_wr !== 1'b1 || out_ram_a !== 32'h204 || out_ram_dout !== 8'hAB || out_ls_ready !== 1'b0) begin
      miscompares++; $display("FAIL store1_write: wr %b a %h dout %h rdy %b want 1 204 ab 0",
                              out_ram_wr, out_ram_a, out_ram_dout, out_ls_ready);
    end
    tick();
    vectors++;
    if (out_ls_ready !== 1'b1 || out_ram_wr !== 1'b0) begin
      miscompares++; $display("FAIL store1_ready: rdy %b wr %b want 1 0", out_ls_ready, out_ram_wr);
    end
    vectors++;
    if (mem[12'h204] !== 8'hAB || mem[12'h205] === 8'h56) begin
      miscompares++; $display("FAIL store1_mem: 204=%h 205=%h want ab and untouched", mem[12'h204], mem[12'h205]);
    end
  endtask

  task automatic test_store_then_load();
    pulse_ls(1'b1, 32'h300, 3'd4, 32'hCAFE8001);
    for (int e = 1; e <= 4; e++) tick();
    tick();
    vectors++;
    if (out_ls_ready !== 1'b1) begin
      miscompares++; $display("FAIL st4_ready: ready %b at edge 5 want 1", out_ls_ready);
    end
    pulse_ls(1'b0, 32'h300, 3'd2, 32'h0);
    for (int e = 1; e <= 3; e++) tick();
    vectors++;
    if (out_ls_ready !== 1'b0) begin
      miscompares++; $display("FAIL ld2_early: ready %b at edge 3 want 0", out_ls_ready);
    end
    tick();
    vectors++;
    if (out_ls_ready !== 1'b1 || out_ls_read_data !== 32'h00008001) begin
      miscompares++; $display("FAIL ld2_data: ready %b data %h want 1 00008001", out_ls_ready, out_ls_read_data);
    end
  endtask

  task automatic test_arbitration();
    in_if_ena = 1'b1; in_if_addr = 32'h0;
    pulse_ls(1'b0, 32'h40, 3'd4, 32'h0);
    in_if_ena = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (e == 6) begin
        vectors++;
        if (out_ls_ready !== 1'b1 || out_ls_read_data !== 32'hA3A2A1A0 || out_if_ready !== 1'b0) begin
          miscompares++; $display("FAIL arb_ls: ls_rdy %b data %h if_rdy %b want 1 a3a2a1a0 0",
                                  out_ls_ready, out_ls_read_data, out_if_ready);
        end
      end else if (e == 8) begin
        vectors++;
        if (out_ram_a !== 32'h0) begin
          miscompares++; $display("FAIL arb_if_start: a %h at edge 8 want 00000000", out_ram_a);
        end
      end else if (e == 12) begin
        vectors++;
        if (out_if_ready !== 1'b0) begin
          miscompares++; $display("FAIL arb_if_early: if_rdy %b at edge 12 want 0", out_if_ready);
        end
      end else if (e == 13) begin
        vectors++;
        if (out_if_ready !== 1'b1 || out_if_data !== 32'h04030201) begin
          miscompares++; $display("FAIL arb_if_data: if_rdy %b data %h want 1 04030201", out_if_ready, out_if_data);
        end
      end
    end
  endtask

  task automatic test_rollback_read();
    int if_seen = 0;
    in_if_ena = 1'b1; in_if_addr = 32'h100;
    tick();
    in_if_ena = 1'b0;
    tick();
    tick();
    in_rollback = 1'b1;
    tick();
    in_rollback = 1'b0;
    if (out_if_ready) if_seen++;
    pulse_ls(1'b0, 32'h101, 3'd1, 32'h0);
    for (int e = 5; e <= 10; e++) begin
      tick();
      if (out_if_ready) if_seen++;
      if (e == 7) begin
        vectors++;
        if (out_ls_ready !== 1'b1 || out_ls_read_data !== 32'h00000022) begin
          miscompares++; $display("FAIL rb_idle_next: ls_rdy %b data %h at edge 7 want 1 00000022",
                                  out_ls_ready, out_ls_read_data);
        end
      end
    end
    vectors++;
    if (if_seen !== 0) begin
      miscompares++; $display("FAIL rb_if_ready: %0d fetch ready pulses want 0", if_seen);
    end
  endtask

  task automatic test_rollback_store();
    logic [7:0] exp_b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int if_seen = 0;
    pulse_ls(1'b1, 32'h310, 3'd4, 32'hDDCCBBAA);
    for (int e = 1; e <= 5; e++) begin
      if (e == 2) begin in_rollback = 1'b1; in_if_ena = 1'b1; in_if_addr = 32'h0; end
      tick();
      in_rollback = 1'b0; in_if_ena = 1'b0;
      if (e <= 4) begin
        vectors++;
        if (out_ram_wr !== 1'b1 || out_ram_a !== 32'h310 + 32'(e - 1) || out_ram_dout !== exp_b[e-1]) begin
          miscompares++; $display("FAIL rbst_write edge%0d: wr %b a %h dout %h want 1 %h %h",
                                  e, out_ram_wr, out_ram_a, out_ram_dout, 32'h310 + 32'(e - 1), exp_b[e-1]);
        end
      end else begin
        vectors++;
        if (out_ls_ready !== 1'b1) begin
          miscompares++; $display("FAIL rbst_ready: ready %b at edge 5 want 1", out_ls_ready);
        end
      end
    end
    for (int e = 6; e <= 14; e++) begin
      tick();
      if (out_if_ready) if_seen++;
    end
    vectors++;
    if (if_seen !== 0) begin
      miscompares++; $display("FAIL rbst_if_dropped: %0d fetch ready pulses want 0", if_seen);
    end
    vectors++;
    if ({mem[12'h313], mem[12'h312], mem[12'h311], mem[12'h310]} !== 32'hDDCCBBAA) begin
      miscompares++; $display("FAIL rbst_mem: got %h want ddccbbaa",
                              {mem[12'h313], mem[12'h312], mem[12'h311], mem[12'h310]});
    end
  endtask

  task automatic test_ena_stall();
    pulse_ls(1'b0, 32'h100, 3'd4, 32'h0);
    tick();
    tick();
    ena = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      vectors++;
      if (out_ram_a !== 32'h101 || out_ls_ready !== 1'b0) begin
        miscompares++; $display("FAIL stall_hold%0d: a %h rdy %b want 101 0", s, out_ram_a, out_ls_ready);
      end
    end
    ena = 1'b1;
    for (int e = 6; e <= 9; e++) begin
      tick();
      if (e == 8) begin
        vectors++;
        if (out_ls_ready !== 1'b0) begin
          miscompares++; $display("FAIL stall_early: ready %b at edge 8 want 0", out_ls_ready);
        end
      end
    end
    vectors++;
    if (out_ls_ready !== 1'b1 || out_ls_read_data !== 32'h44332211) begin
      miscompares++; $display("FAIL stall_data: ready %b data %h want 1 44332211", out_ls_ready, out_ls_read_data);
    end
  endtask

  task automatic test_size_wrap();
    pulse_ls(1'b0, 32'hFFFFFFFE, 3'd3, 32'h0);
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 3) begin
        vectors++;
        if (out_ram_a !== 32'h00000000) begin
          miscompares++; $display("FAIL wrap_addr: a %h at edge 3 want 00000000", out_ram_a);
        end
      end
    end
    vectors++;
    if (out_ls_ready !== 1'b1 || out_ls_read_data !== 32'h02016677) begin
      miscompares++; $display("FAIL size3_as4: ready %b data %h want 1 02016677", out_ls_ready, out_ls_read_data);
    end
  endtask

  task automatic test_reset_mid_store();
    int strobes = 0;
    pulse_ls(1'b1, 32'h320, 3'd4, 32'h11111111);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (out_ram_wr !== 1'b0 || out_ls_ready !== 1'b0 || out_if_ready !== 1'b0) begin
      miscompares++; $display("FAIL rst_abort: wr %b ls_rdy %b if_rdy %b want 0 0 0",
                              out_ram_wr, out_ls_ready, out_if_ready);
    end
    vectors++;
    if (out_ls_read_data !== 32'h0 || out_ram_a !== 32'h0) begin
      miscompares++; $display("FAIL rst_clear: ls_data %h a %h want 0 0", out_ls_read_data, out_ram_a);
    end
    for (int e = 0; e < 6; e++) begin
      tick();
      if (out_ram_wr || out_ls_ready || out_if_ready) strobes++;
    end
    vectors++;
    if (strobes !== 0) begin
      miscompares++; $display("FAIL rst_quiet: %0d strobe cycles after reset want 0", strobes);
    end
    pulse_ls(1'b0, 32'h204, 3'd1, 32'h0);
    tick();
    tick();
    tick();
    vectors++;
    if (out_ls_ready !== 1'b1 || out_ls_read_data !== 32'h000000AB) begin
      miscompares++; $display("FAIL rst_fresh: ready %b data %h want 1 000000ab", out_ls_ready, out_ls_read_data);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_store_then_load();
    test_arbitration();
    test_rollback_read();
    test_rollback_store();
    test_ena_stall();
    test_size_wrap();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
